// File: rtl/key_encoder_if.sv
// Button and key-code bundle between the panel driver and key_encoder.
// The master drives the raw buttons; the slave returns key pulses and the hold flag.
interface key_encoder_if;
  logic       btn_down;
  logic       btn_left;
  logic       btn_up;
  logic       btn_right;
  logic       btn_select;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    output btn_down, btn_left, btn_up, btn_right, btn_select,
    input  key_code, key_held
  );

  modport slave (
    input  btn_down, btn_left, btn_up, btn_right, btn_select,
    output key_code, key_held
  );
endinterface

// File: rtl/key_encoder.sv
// Synchronizes and debounces five push-buttons and turns accepted presses into
// one-cycle key codes, with auto-repeat for the four direction keys.
module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input logic          clock,
  input logic          reset,
  key_encoder_if.slave keys
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);
  localparam logic [2:0] SEL_IDX = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEAT
  } state_t;

  logic [4:0]    rawBtn;
  logic [4:0]    sync1_q, sync2_q, db_q, dbPrev_q;
  logic [CW-1:0] dbCnt_q [5];
  logic [4:0]    press;

  state_t        state_q, state_d;
  logic [2:0]    lock_q, lock_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    keyCode_q, keyCode_d;
  logic [2:0]    pick;
  logic          lockedDb;
  logic [3:0]    lockCode;

  // Bit index i carries key code i+1, so the lowest set bit wins priority.
  assign rawBtn = {keys.btn_select, keys.btn_right, keys.btn_up, keys.btn_left, keys.btn_down};

  // A new level is accepted only after the counter has reached DEBOUNCE_CYCLES
  // and the synchronized sample still disagrees; any agreeing sample restarts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      dbPrev_q <= '0;
      for (int i = 0; i < 5; i++) dbCnt_q[i] <= '0;
    end else begin
      sync1_q  <= rawBtn;
      sync2_q  <= sync1_q;
      dbPrev_q <= db_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          dbCnt_q[i] <= '0;
        end else if (dbCnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
          db_q[i]    <= sync2_q[i];
          dbCnt_q[i] <= '0;
        end else begin
          dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press    = db_q & ~dbPrev_q;
  assign lockedDb = db_q[lock_q];
  assign lockCode = {1'b0, lock_q} + 4'd1;

  always_comb begin
    pick = '0;
    for (int i = 4; i >= 0; i--) begin
      if (press[i]) pick = 3'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_q    <= '0;
      timer_q   <= '0;
      keyCode_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      timer_q   <= timer_d;
      keyCode_q <= keyCode_d;
    end
  end

  // Release is tested before the timer so a falling level never emits a pulse.
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    timer_d   = timer_q;
    keyCode_d = '0;
    case (state_q)
      IDLE: begin
        if (|press) begin
          lock_d    = pick;
          keyCode_d = {1'b0, pick} + 4'd1;
          timer_d   = TW'(REPEAT_DELAY - 1);
          state_d   = PRESSED;
        end
      end
      PRESSED: begin
        if (!lockedDb) begin
          state_d = IDLE;
        end else if (lock_q != SEL_IDX) begin
          if (timer_q == '0) begin
            keyCode_d = lockCode;
            timer_d   = TW'(REPEAT_PERIOD - 1);
            state_d   = REPEAT;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!lockedDb) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          keyCode_d = lockCode;
          timer_d   = TW'(REPEAT_PERIOD - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign keys.key_code = keyCode_q;
  assign keys.key_held = (state_q != IDLE);

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: directed button scenarios plus random button traffic,
// compared every cycle against an event-schedule model of the encoder.
module tb_key_encoder;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] DOWN  = 5'b00001;
  localparam logic [4:0] LEFT  = 5'b00010;
  localparam logic [4:0] UP    = 5'b00100;
  localparam logic [4:0] RIGHT = 5'b01000;
  localparam logic [4:0] SEL   = 5'b10000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn   = '0;

  int checks = 0;
  int errors = 0;
  int edgeNo = 0;

  key_encoder_if keys ();

  assign keys.btn_down   = btn[0];
  assign keys.btn_left   = btn[1];
  assign keys.btn_up     = btn[2];
  assign keys.btn_right  = btn[3];
  assign keys.btn_select = btn[4];

  key_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .keys (keys)
  );

  always #5 clock = ~clock;

  // Reference: synchronizer as a two-deep delay, debounce as a run length of
  // disagreeing samples, repeats as absolute edge numbers of the next pulse.
  logic [4:0] mS1 = '0, mS2 = '0, mDb = '0, mDbPrev = '0;
  int         mRun [5];
  int         mState = 0;
  int         mLock  = 0;
  int         mNext  = 0;
  int         mKey   = 0;

  int codeCount [16];
  int firstPulseEdge;

  task automatic modelEdge(input logic [4:0] b, input logic r);
    logic [4:0] press;
    logic [4:0] dbNew;
    int key;
    edgeNo++;
    if (r) begin
      mS1 = '0; mS2 = '0; mDb = '0; mDbPrev = '0;
      for (int i = 0; i < 5; i++) mRun[i] = 0;
      mState = 0; mLock = 0; mNext = 0; mKey = 0;
      return;
    end
    press = mDb & ~mDbPrev;
    key   = 0;
    if (mState == 0) begin
      if (press != 0) begin
        for (int i = 4; i >= 0; i--) if (press[i]) mLock = i;
        key    = mLock + 1;
        mState = 1;
        mNext  = edgeNo + RD;
      end
    end else if (!mDb[mLock]) begin
      mState = 0;
    end else if (mLock != 4 && edgeNo == mNext) begin
      key    = mLock + 1;
      mNext  = edgeNo + RP;
      mState = 2;
    end
    dbNew = mDb;
    for (int i = 0; i < 5; i++) begin
      if (mS2[i] != mDb[i]) begin
        mRun[i]++;
        if (mRun[i] > DEB) begin
          dbNew[i] = mS2[i];
          mRun[i]  = 0;
        end
      end else begin
        mRun[i] = 0;
      end
    end
    mDbPrev = mDb;
    mDb     = dbNew;
    mS2     = mS1;
    mS1     = b;
    mKey    = key;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, observed, expected, edgeNo);
    end
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 16; i++) codeCount[i] = 0;
    firstPulseEdge = -1;
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic r, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      btn   = b;
      reset = r;
      @(posedge clock);
      modelEdge(b, r);
      #1;
      checkOutput("key_code", int'(keys.key_code), mKey);
      checkOutput("key_held", int'(keys.key_held), (mState != 0) ? 1 : 0);
      if (keys.key_code != 4'd0) begin
        codeCount[keys.key_code]++;
        if (firstPulseEdge < 0) firstPulseEdge = edgeNo;
      end
    end
  endtask

  function automatic int nonzeroCount();
    int n = 0;
    for (int i = 1; i < 16; i++) n += codeCount[i];
    return n;
  endfunction

  initial begin
    int startEdge;
    int resetEdge;
    logic [4:0] rb;
    logic rr;

    for (int i = 0; i < 5; i++) mRun[i] = 0;
    clearCounts();

    applyStimulus(NONE, 1'b1, 3);
    checkOutput("reset_key_code", int'(keys.key_code), 0);
    checkOutput("reset_key_held", int'(keys.key_held), 0);
    applyStimulus(NONE, 1'b0, 4);

    // Press-and-release latency
    clearCounts();
    startEdge = edgeNo + 1;
    applyStimulus(RIGHT, 1'b0, 6);
    applyStimulus(NONE, 1'b0, 20);
    checkOutput("right_pulse_count", codeCount[4], 1);
    checkOutput("right_other_codes", nonzeroCount(), 1);
    checkOutput("right_latency", firstPulseEdge - startEdge, 7);

    // Glitch rejection
    clearCounts();
    applyStimulus(UP, 1'b0, 1);
    applyStimulus(NONE, 1'b0, 5);
    applyStimulus(UP, 1'b0, 2);
    applyStimulus(NONE, 1'b0, 5);
    applyStimulus(UP, 1'b0, 3);
    applyStimulus(NONE, 1'b0, 12);
    checkOutput("glitch_codes", nonzeroCount(), 0);

    // Auto-repeat: pulses at T, T+10, +13 ... +28 while db is high
    clearCounts();
    startEdge = edgeNo + 1;
    applyStimulus(DOWN, 1'b0, 30);
    applyStimulus(NONE, 1'b0, 15);
    checkOutput("repeat_first_latency", firstPulseEdge - startEdge, 7);
    checkOutput("repeat_pulse_count", codeCount[1], 8);

    // Select never repeats
    clearCounts();
    applyStimulus(SEL, 1'b0, 30);
    checkOutput("select_held", int'(keys.key_held), 1);
    applyStimulus(NONE, 1'b0, 15);
    checkOutput("select_pulse_count", codeCount[5], 1);
    checkOutput("select_other_codes", nonzeroCount(), 1);

    // Simultaneous presses and lockout
    clearCounts();
    applyStimulus(LEFT | UP, 1'b0, 8);
    applyStimulus(LEFT, 1'b0, 3);
    applyStimulus(LEFT | RIGHT, 1'b0, 8);
    applyStimulus(LEFT, 1'b0, 4);
    applyStimulus(NONE, 1'b0, 15);
    checkOutput("simul_left_seen", (codeCount[2] > 0) ? 1 : 0, 1);
    checkOutput("simul_no_up", codeCount[3], 0);
    checkOutput("lockout_no_right", codeCount[4], 0);
    clearCounts();
    applyStimulus(RIGHT, 1'b0, 8);
    applyStimulus(NONE, 1'b0, 15);
    checkOutput("repress_right", codeCount[4], 1);

    // Reset mid-hold with down still pressed
    applyStimulus(DOWN, 1'b0, 25);
    applyStimulus(DOWN, 1'b1, 1);
    resetEdge = edgeNo;
    checkOutput("midreset_key_code", int'(keys.key_code), 0);
    checkOutput("midreset_key_held", int'(keys.key_held), 0);
    clearCounts();
    applyStimulus(DOWN, 1'b0, 12);
    checkOutput("midreset_repress_latency", firstPulseEdge - resetEdge, 8);
    applyStimulus(NONE, 1'b0, 15);

    // Random button traffic with occasional resets
    for (int s = 0; s < 120; s++) begin
      rb = '0;
      for (int i = 0; i < 5; i++) rb[i] = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 40) == 0);
      applyStimulus(rb, rr, rr ? 1 : $urandom_range(1, 20));
    end
    applyStimulus(NONE, 1'b0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
